// File: rtl/memdatos_pkg.sv
// -----------------------------------------------------------------------------
// memdatos_pkg
// Shared constants and types for the data-memory arbiter.
//   DEPTH     : number of memory words, legal word addresses 0..DEPTH-1
//   AW, DW    : address and data widths
//   MAX_BURST : longest run of consecutive grants one locked requester may take
//   CNT_W     : width of the burst counter (must be able to hold MAX_BURST)
//   state_t   : arbiter ownership state
// -----------------------------------------------------------------------------
package memdatos_pkg;

    localparam int DEPTH     = 100;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = $clog2(MAX_BURST + 1);

    // IDLE: open round-robin arbitration; OWNx: requester x holds a locked burst
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/arbitro_memdatos_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   req   : request vector, bit i = requester i
//   last  : requester that was served most recently
//   sel   : chosen requester index (meaningful only when valid)
//   valid : at least one requester is asking
// A lone requester always wins; on a tie the one that was not served last wins.
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            sel = ~last;
        end else begin
            sel = req[1];
        end
    end

endmodule

// File: rtl/arbitro_memdatos.sv
// -----------------------------------------------------------------------------
// arbitro_memdatos
// Arbiter and sequencer sharing the data memory between requester 0 (CPU
// load/store stage) and requester 1 (DMA/debug port).
//   clk, rst_n                 : clock and asynchronous active-low reset
//   reqX, weX, lockX           : request, write enable, burst lock of requester X
//   addrX, wdataX              : word address and write data of requester X
//   gntX                       : combinational grant, transfer happens this cycle
//   doneX, rdataX, errX        : registered response, one cycle after gntX
//   mem_addr, mem_data         : address / write data towards the memory
//   mem_write, mem_read        : memory strobes, suppressed for bad addresses
//   mem_rdata                  : combinational read data from the memory
// -----------------------------------------------------------------------------
module arbitro_memdatos
    import memdatos_pkg::*;
#(
    parameter int P_DEPTH     = DEPTH,
    parameter int P_AW        = AW,
    parameter int P_DW        = DW,
    parameter int P_MAX_BURST = MAX_BURST
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0,
    input  logic            we0,
    input  logic            lock0,
    input  logic [P_AW-1:0] addr0,
    input  logic [P_DW-1:0] wdata0,
    output logic            gnt0,
    output logic            done0,
    output logic [P_DW-1:0] rdata0,
    output logic            err0,

    input  logic            req1,
    input  logic            we1,
    input  logic            lock1,
    input  logic [P_AW-1:0] addr1,
    input  logic [P_DW-1:0] wdata1,
    output logic            gnt1,
    output logic            done1,
    output logic [P_DW-1:0] rdata1,
    output logic            err1,

    output logic [P_AW-1:0] mem_addr,
    output logic [P_DW-1:0] mem_data,
    output logic            mem_write,
    output logic            mem_read,
    input  logic [P_DW-1:0] mem_rdata
);

    localparam int CW = $clog2(P_MAX_BURST + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last;

    logic            pick_sel;
    logic            pick_valid;
    logic            ok0;
    logic            ok1;
    logic            any_gnt;
    logic            sel_we;
    logic            sel_ok;
    logic [P_AW-1:0] sel_addr;
    logic [P_DW-1:0] sel_data;
    logic            burst_room;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    // Full-width unsigned compare: large addresses must never alias a low word.
    assign ok0 = addr0 < P_AW'(P_DEPTH);
    assign ok1 = addr1 < P_AW'(P_DEPTH);

    assign burst_room = cnt < CW'(P_MAX_BURST);

    // Grant decision. Gating with rst_n keeps every grant, and therefore any
    // memory write, from reaching the clock edge while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt0 = ~pick_sel;
                    gnt1 = pick_sel;
                end
            end
            OWN0:    gnt0 = req0 & lock0 & burst_room;
            OWN1:    gnt1 = req1 & lock1 & burst_room;
            default: ;
        endcase
        gnt0 = gnt0 & rst_n;
        gnt1 = gnt1 & rst_n;
    end

    // Steer the granted requester onto the memory bus; an out-of-range
    // address still shows up on mem_addr but never strobes the memory.
    always_comb begin
        any_gnt  = gnt0 | gnt1;
        sel_we   = gnt1 ? we1    : we0;
        sel_ok   = gnt1 ? ok1    : ok0;
        sel_addr = gnt1 ? addr1  : addr0;
        sel_data = gnt1 ? wdata1 : wdata0;

        mem_addr  = any_gnt ? sel_addr : '0;
        mem_data  = any_gnt ? sel_data : '0;
        mem_write = any_gnt & sel_ok & sel_we;
        mem_read  = any_gnt & sel_ok & ~sel_we;
    end

    // Ownership FSM. Leaving OWNx spends one cycle with no grant and records
    // x as last served so the other requester wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            if (any_gnt) begin
                last <= gnt1;
            end
            unique case (state)
                IDLE: begin
                    if (gnt0 && lock0) begin
                        state <= OWN0;
                        cnt   <= CW'(1);
                    end else if (gnt1 && lock1) begin
                        state <= OWN1;
                        cnt   <= CW'(1);
                    end
                end
                OWN0: begin
                    if (gnt0) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        last  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (gnt1) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        last  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Registered responses; read data only updates on an in-range read so
    // writes and errors leave the previous value visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done0  <= 1'b0;
            done1  <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            done0 <= gnt0;
            done1 <= gnt1;
            err0  <= gnt0 & ~ok0;
            err1  <= gnt1 & ~ok1;
            if (gnt0 && !we0 && ok0) begin
                rdata0 <= mem_rdata;
            end
            if (gnt1 && !we1 && ok1) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_memdatos.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memdatos
// Self-checking bench: two transaction queues feed the requesters, a small
// memory sits on the memory port, and a transaction-level reference model
// (owner / burst length / last served, plus a reference memory array) predicts
// grants, memory strobes and responses every cycle.
// -----------------------------------------------------------------------------
module tb_arbitro_memdatos;
    import memdatos_pkg::*;

    typedef struct packed {
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, done0, err0, gnt1, done1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_data, mem_rdata;
    logic        mem_write, mem_read;

    always #5 clk = ~clk;

    arbitro_memdatos dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .lock0     (lock0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .done0     (done0),
        .rdata0    (rdata0),
        .err0      (err0),
        .req1      (req1),
        .we1       (we1),
        .lock1     (lock1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .done1     (done1),
        .rdata1    (rdata1),
        .err1      (err1),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
    );

    // Data memory attached to the arbiter: preloaded on the first edge,
    // synchronous write, combinational read.
    logic [31:0] mem [0:DEPTH-1];
    logic        mem_loaded = 1'b0;

    function automatic logic [31:0] seed_word(int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_write && mem_addr < DEPTH) begin
            mem[mem_addr] <= mem_data;
        end
    end

    assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr] : 32'h0;

    // Reference model state
    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_owner;
    int          m_cnt;
    int          m_last;
    logic [31:0] exp_rdata [2];
    logic        exp_done [2];
    logic        exp_err [2];
    int          checks = 0;
    int          failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic txn_t mk(logic we, logic lock, logic [31:0] addr, logic [31:0] wdata);
        txn_t t;
        t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        for (int i = 0; i < 2; i++) begin
            exp_rdata[i] = '0; exp_done[i] = 1'b0; exp_err[i] = 1'b0;
        end
    endtask

    // Who should be served this cycle, from ownership and round-robin rules.
    function automatic int model_grant();
        if (m_owner == 0) return (req0 && lock0 && m_cnt < MAX_BURST) ? 0 : -1;
        if (m_owner == 1) return (req1 && lock1 && m_cnt < MAX_BURST) ? 1 : -1;
        if (req0 && req1) return 1 - m_last;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_advance(int g);
        if (m_owner >= 0 && g < 0) begin
            m_last  = m_owner;
            m_owner = -1;
            m_cnt   = 0;
        end else if (g >= 0) begin
            m_last = g;
            if (m_owner < 0) begin
                if ((g == 0) ? lock0 : lock1) begin
                    m_owner = g;
                    m_cnt   = 1;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic load_inputs();
        txn_t t;
        req0 = (q0.size() != 0);
        t = req0 ? q0[0] : '0;
        we0 = t.we; lock0 = t.lock; addr0 = t.addr; wdata0 = t.wdata;
        req1 = (q1.size() != 0);
        t = req1 ? q1[0] : '0;
        we1 = t.we; lock1 = t.lock; addr1 = t.addr; wdata1 = t.wdata;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_gnt"},   {30'b0, gnt1, gnt0}, 32'h0);
        checkOutput({tag, "_done"},  {30'b0, done1, done0}, 32'h0);
        checkOutput({tag, "_err"},   {30'b0, err1, err0}, 32'h0);
        checkOutput({tag, "_rd0"},   rdata0, 32'h0);
        checkOutput({tag, "_rd1"},   rdata1, 32'h0);
        checkOutput({tag, "_maddr"}, mem_addr, 32'h0);
        checkOutput({tag, "_mdata"}, mem_data, 32'h0);
        checkOutput({tag, "_mstb"},  {30'b0, mem_write, mem_read}, 32'h0);
    endtask

    // One clock cycle, entered and left just after a rising edge.
    task automatic applyStimulus();
        int   g;
        logic ok;
        txn_t t;
        load_inputs();
        @(negedge clk);
        g = model_grant();
        t = '0;
        if (g == 0) t = q0[0];
        if (g == 1) t = q1[0];
        ok = (g >= 0) && (t.addr < DEPTH);
        checkOutput("gnt0", gnt0, (g == 0));
        checkOutput("gnt1", gnt1, (g == 1));
        checkOutput("mem_write", mem_write, ok && t.we);
        checkOutput("mem_read", mem_read, ok && !t.we);
        checkOutput("mem_addr", mem_addr, (g >= 0) ? t.addr : 32'h0);
        checkOutput("mem_data", mem_data, (g >= 0) ? t.wdata : 32'h0);
        @(posedge clk);
        exp_done[0] = 1'b0; exp_done[1] = 1'b0;
        exp_err[0]  = 1'b0; exp_err[1]  = 1'b0;
        if (g >= 0) begin
            exp_done[g] = 1'b1;
            exp_err[g]  = !ok;
            if (ok && t.we) ref_mem[t.addr] = t.wdata;
            if (ok && !t.we) exp_rdata[g] = ref_mem[t.addr];
            if (g == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
        model_advance(g);
        #1;
        checkOutput("done0", done0, exp_done[0]);
        checkOutput("done1", done1, exp_done[1]);
        checkOutput("err0", err0, exp_err[0]);
        checkOutput("err1", err1, exp_err[1]);
        checkOutput("rdata0", rdata0, exp_rdata[0]);
        checkOutput("rdata1", rdata1, exp_rdata[1]);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout observed=pending expected=empty");
            q0.delete();
            q1.delete();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'd100;
            1:       return 32'hFFFFFFFF;
            2:       return $urandom;
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic push_burst(input int who);
        int   n    = $urandom_range(1, 6);
        logic lk   = $urandom_range(0, 1) == 1;
        txn_t t;
        for (int i = 0; i < n; i++) begin
            t = mk($urandom_range(0, 1) == 1, lk && (i != n - 1 || $urandom_range(0, 1) == 1),
                   rand_addr(), $urandom);
            if (who == 0) q0.push_back(t);
            else          q1.push_back(t);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        model_reset();
        load_inputs();

        // Reset defaults
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First contest: requester 0 wins after reset
        q0.push_back(mk(1'b0, 1'b0, 32'd5, 32'h0));
        q1.push_back(mk(1'b0, 1'b0, 32'd6, 32'h0));
        drain(10);

        // Write then read of the same word
        q0.push_back(mk(1'b1, 1'b0, 32'd10, 32'hDEADBEEF));
        q1.push_back(mk(1'b0, 1'b0, 32'd10, 32'h0));
        drain(10);
        checkOutput("wr_rd_rdata1", rdata1, 32'hDEADBEEF);

        // Burst limit with a competing requester
        for (int i = 0; i < 6; i++) q0.push_back(mk(1'b0, 1'b1, 32'(20 + i), 32'h0));
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 1'b0, 32'(40 + i), 32'h0));
        drain(30);

        // Out-of-range writes leave memory alone
        q1.push_back(mk(1'b1, 1'b0, 32'd100, 32'h11111111));
        q1.push_back(mk(1'b1, 1'b0, 32'hFFFFFFFF, 32'h22222222));
        q1.push_back(mk(1'b0, 1'b0, 32'd0, 32'h0));
        drain(10);

        // Reset pulse in the middle of a granted write
        q0.push_back(mk(1'b1, 1'b0, 32'd3, 32'hCAFEF00D));
        load_inputs();
        @(negedge clk);
        checkOutput("rst_mid_gnt0", gnt0, (model_grant() == 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check_all_zero("rst_edge");
        q0.delete();
        model_reset();
        load_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q1.push_back(mk(1'b0, 1'b0, 32'd3, 32'h0));
        drain(10);

        // Locked owner drops lock while the other requester waits
        q1.push_back(mk(1'b0, 1'b1, 32'd7, 32'h0));
        q1.push_back(mk(1'b0, 1'b1, 32'd8, 32'h0));
        q1.push_back(mk(1'b0, 1'b0, 32'd9, 32'h0));
        applyStimulus();
        q0.push_back(mk(1'b0, 1'b0, 32'd10, 32'h0));
        drain(20);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) push_burst(0);
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) push_burst(1);
            applyStimulus();
        end
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
